// File: rtl/hp_pkg.sv
// hp_pkg: shared definitions for the HP-bar controller.
//   - FSM state encoding (OFF, ALIVE, INVUL, DEAD)
//   - 12-bit RGB colour constants (WHITE, GREEN, RED)
//   - hp_width(): bit width needed to hold 0..max_hp
package hp_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_ALIVE = 2'd1;
    localparam logic [1:0] ST_INVUL = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    localparam logic [11:0] WHITE = 12'hf_f_f;
    localparam logic [11:0] GREEN = 12'h0_f_0;
    localparam logic [11:0] RED   = 12'hf_0_0;

    function automatic int hp_width(input int max_hp);
        return (max_hp < 1) ? 1 : $clog2(max_hp + 1);
    endfunction

endpackage

// File: rtl/hp_bar_draw.sv
// hp_bar_draw: registered pixel stage that overlays the framed HP bar.
// Ports:
//   pclk, rst_n        pixel clock, async active-low reset
//   i_hcount, i_vcount current pixel position
//   i_rgb              upstream pixel colour
//   i_hp               HP value used for the fill length
//   i_draw_en          0 passes i_rgb through untouched
//   i_low              selects red fill instead of green
//   i_fill_en          0 suppresses the fill (frame still drawn)
//   o_rgb              pixel colour, one pclk behind the inputs
module hp_bar_draw
    import hp_pkg::*;
#(
    parameter int MAX_HP   = 5,
    parameter int SEG_W    = 60,
    parameter int BAR_LEFT = 361,
    parameter int BAR_TOP  = 737,
    parameter int BAR_H    = 50,
    parameter int BORDER   = 10,
    parameter int HPW      = hp_width(MAX_HP)
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic [11:0]    i_hcount,
    input  logic [11:0]    i_vcount,
    input  logic [11:0]    i_rgb,
    input  logic [HPW-1:0] i_hp,
    input  logic           i_draw_en,
    input  logic           i_low,
    input  logic           i_fill_en,
    output logic [11:0]    o_rgb
);

    localparam int X_IN_L = BAR_LEFT;
    localparam int X_IN_R = BAR_LEFT + MAX_HP * SEG_W;
    localparam int Y_IN_T = BAR_TOP;
    localparam int Y_IN_B = BAR_TOP + BAR_H;

    int          w_x;
    int          w_y;
    int          w_fill_r;
    logic        w_in_int;
    logic        w_in_ring;
    logic [11:0] w_rgb_nxt;
    logic [11:0] r_rgb;

    // Geometry is evaluated in 32-bit signed space so a bar placed near
    // x=0 / y=0 (negative outer frame edge) still compares correctly.
    always_comb begin
        w_x       = int'({20'd0, i_hcount});
        w_y       = int'({20'd0, i_vcount});
        w_fill_r  = X_IN_L + int'({{(32-HPW){1'b0}}, i_hp}) * SEG_W;
        w_in_int  = (w_x >= X_IN_L) && (w_x < X_IN_R) &&
                    (w_y >= Y_IN_T) && (w_y < Y_IN_B);
        w_in_ring = !w_in_int &&
                    (w_x >= X_IN_L - BORDER) && (w_x < X_IN_R + BORDER) &&
                    (w_y >= Y_IN_T - BORDER) && (w_y < Y_IN_B + BORDER);
        w_rgb_nxt = i_rgb;
        if (i_draw_en) begin
            if (w_in_ring) begin
                w_rgb_nxt = WHITE;
            end else if (w_in_int && i_fill_en && (w_x < w_fill_r)) begin
                w_rgb_nxt = i_low ? RED : GREEN;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= w_rgb_nxt;
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/hp_bar_ctrl.sv
// hp_bar_ctrl: player-HP controller plus HP-bar overlay in the VGA pipeline.
// Tracks HP (variable damage, +1 healing), frame-counted invulnerability
// after a hit, and pulses game_over for one cycle on death.
//
// state | meaning
// OFF   | no game running; bar not drawn, HP parked at MAX_HP
// ALIVE | game running, hits and heals accepted
// INVUL | post-hit grace period; hits ignored, heals accepted
// DEAD  | HP is 0; only the bar frame is drawn until game_on drops
//
// Ports: pclk, rst_n; VGA timing in/out (vcount, hcount, vsync, vblnk,
// hsync, hblnk, rgb) with 1-pclk latency; game_on, hit, dmg_amount, heal;
// hp_level, invul, game_over.
// Build option: HP_BAR_BLINK_EN makes the fill blink during INVUL
// (fill hidden while counter bit 2 is set).
module hp_bar_ctrl
    import hp_pkg::*;
#(
    parameter int MAX_HP       = 5,
    parameter int SEG_W        = 60,
    parameter int BAR_LEFT     = 361,
    parameter int BAR_TOP      = 737,
    parameter int BAR_H        = 50,
    parameter int BORDER       = 10,
    parameter int DMG_W        = 3,
    parameter int INVUL_FRAMES = 60,
    parameter int LOW_HP       = 1
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic [11:0]                   vcount_in,
    input  logic [11:0]                   hcount_in,
    input  logic                          vsync_in,
    input  logic                          vblnk_in,
    input  logic                          hsync_in,
    input  logic                          hblnk_in,
    input  logic [11:0]                   rgb_in,
    input  logic                          game_on,
    input  logic                          hit,
    input  logic [DMG_W-1:0]              dmg_amount,
    input  logic                          heal,
    output logic [11:0]                   vcount_out,
    output logic [11:0]                   hcount_out,
    output logic                          vsync_out,
    output logic                          vblnk_out,
    output logic                          hsync_out,
    output logic                          hblnk_out,
    output logic [11:0]                   rgb_out,
    output logic [hp_width(MAX_HP)-1:0]   hp_level,
    output logic                          invul,
    output logic                          game_over
);

    localparam int HPW = hp_width(MAX_HP);
    localparam int CW  = ($clog2(INVUL_FRAMES + 1) > 3) ? $clog2(INVUL_FRAMES + 1) : 3;
    localparam int AW  = ((HPW > DMG_W) ? HPW : DMG_W) + 1;
    localparam logic [HPW-1:0] HP_MAX   = HPW'(MAX_HP);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(INVUL_FRAMES);
    localparam logic [31:0]    LOW_U    = LOW_HP;

    logic [1:0]     r_state;
    logic [HPW-1:0] r_hp;
    logic [CW-1:0]  r_cnt;
    logic           r_vs_prev;
    logic           r_game_over;

    logic [11:0]    r_vcount;
    logic [11:0]    r_hcount;
    logic           r_vsync;
    logic           r_vblnk;
    logic           r_hsync;
    logic           r_hblnk;

    logic           w_tick;
    logic [AW-1:0]  w_diff;
    logic [HPW-1:0] w_hp_sub;
    logic [HPW-1:0] w_hp_inc;
    logic           w_low;
    logic           w_fill_en;
    logic           w_draw_en;

    assign w_tick = vsync_in & ~r_vs_prev;

    // Both operands are zero-extended by one bit, so the MSB of the
    // difference is the borrow: damage larger than HP clamps to 0.
    assign w_diff   = AW'(r_hp) - AW'(dmg_amount);
    assign w_hp_sub = w_diff[AW-1] ? '0 : w_diff[HPW-1:0];
    assign w_hp_inc = (r_hp >= HP_MAX) ? HP_MAX : r_hp + HPW'(1);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_hp        <= HP_MAX;
            r_cnt       <= '0;
            r_vs_prev   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_vs_prev   <= vsync_in;
            r_game_over <= 1'b0;
            if (!game_on) begin
                r_state <= ST_OFF;
                r_hp    <= HP_MAX;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state <= ST_ALIVE;
                        r_hp    <= HP_MAX;
                        r_cnt   <= '0;
                    end
                    ST_ALIVE: begin
                        // A hit in the same cycle as a heal wins; the heal is lost.
                        if (hit) begin
                            r_hp <= w_hp_sub;
                            if (w_hp_sub == '0) begin
                                r_state     <= ST_DEAD;
                                r_game_over <= 1'b1;
                            end else if (INVUL_FRAMES > 0) begin
                                r_state <= ST_INVUL;
                                r_cnt   <= CNT_LOAD;
                            end
                        end else if (heal) begin
                            r_hp <= w_hp_inc;
                        end
                    end
                    ST_INVUL: begin
                        if (heal) begin
                            r_hp <= w_hp_inc;
                        end
                        if (w_tick) begin
                            if (r_cnt <= CW'(1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_ALIVE;
                            end else begin
                                r_cnt <= r_cnt - CW'(1);
                            end
                        end
                    end
                    ST_DEAD: begin
                        r_hp <= '0;
                    end
                    default: begin
                        r_state <= ST_OFF;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcount <= 12'd0;
            r_hcount <= 12'd0;
            r_vsync  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_hsync  <= 1'b0;
            r_hblnk  <= 1'b0;
        end else begin
            r_vcount <= vcount_in;
            r_hcount <= hcount_in;
            r_vsync  <= vsync_in;
            r_vblnk  <= vblnk_in;
            r_hsync  <= hsync_in;
            r_hblnk  <= hblnk_in;
        end
    end

    assign w_low     = ({{(32-HPW){1'b0}}, r_hp} <= LOW_U);
    assign w_draw_en = (r_state != ST_OFF);

`ifdef HP_BAR_BLINK_EN
    assign w_fill_en = !((r_state == ST_INVUL) && r_cnt[2]);
`else
    assign w_fill_en = 1'b1;
`endif

    hp_bar_draw #(
        .MAX_HP   (MAX_HP),
        .SEG_W    (SEG_W),
        .BAR_LEFT (BAR_LEFT),
        .BAR_TOP  (BAR_TOP),
        .BAR_H    (BAR_H),
        .BORDER   (BORDER),
        .HPW      (HPW)
    ) u_draw (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .i_hcount  (hcount_in),
        .i_vcount  (vcount_in),
        .i_rgb     (rgb_in),
        .i_hp      (r_hp),
        .i_draw_en (w_draw_en),
        .i_low     (w_low),
        .i_fill_en (w_fill_en),
        .o_rgb     (rgb_out)
    );

    assign vcount_out = r_vcount;
    assign hcount_out = r_hcount;
    assign vsync_out  = r_vsync;
    assign vblnk_out  = r_vblnk;
    assign hsync_out  = r_hsync;
    assign hblnk_out  = r_hblnk;
    assign hp_level   = r_hp;
    assign invul      = (r_state == ST_INVUL);
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_hp_bar_ctrl.sv
`timescale 1ns/1ps
module tb_hp_bar_ctrl;

    localparam int MAX_HP       = 5;
    localparam int SEG_W        = 60;
    localparam int BAR_LEFT     = 361;
    localparam int BAR_TOP      = 737;
    localparam int BAR_H        = 50;
    localparam int BORDER       = 10;
    localparam int DMG_W        = 3;
    localparam int INVUL_FRAMES = 60;
    localparam int LOW_HP       = 1;

    localparam int M_OFF = 0, M_ALIVE = 1, M_INVUL = 2, M_DEAD = 3;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [11:0] vcount_in, hcount_in, rgb_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic        game_on, hit, heal;
    logic [2:0]  dmg_amount;
    logic [11:0] vcount_out, hcount_out, rgb_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [2:0]  hp_level;
    logic        invul, game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_mode, m_hp, m_cnt;
    logic        m_vs_prev, m_go;
    logic [11:0] e_rgb, e_hc, e_vc;
    logic [3:0]  e_sync;

    always #5 pclk = ~pclk;

    hp_bar_ctrl dut (
        .pclk(pclk), .rst_n(rst_n),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .game_on(game_on), .hit(hit), .dmg_amount(dmg_amount), .heal(heal),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .hp_level(hp_level), .invul(invul), .game_over(game_over)
    );

    function automatic void model_reset();
        m_mode = M_OFF; m_hp = MAX_HP; m_cnt = 0; m_vs_prev = 1'b0; m_go = 1'b0;
    endfunction

    function automatic void model_step();
        logic rise;
        rise = vsync_in && !m_vs_prev;
        m_vs_prev = vsync_in;
        m_go = 1'b0;
        if (!game_on) begin
            m_mode = M_OFF; m_hp = MAX_HP; m_cnt = 0;
        end else if (m_mode == M_OFF) begin
            m_mode = M_ALIVE; m_hp = MAX_HP;
        end else if (m_mode == M_ALIVE) begin
            if (hit) begin
                if (m_hp - int'(dmg_amount) <= 0) begin
                    m_hp = 0; m_mode = M_DEAD; m_go = 1'b1;
                end else begin
                    m_hp = m_hp - int'(dmg_amount);
                    m_mode = M_INVUL; m_cnt = INVUL_FRAMES;
                end
            end else if (heal) begin
                m_hp = (m_hp + 1 > MAX_HP) ? MAX_HP : m_hp + 1;
            end
        end else if (m_mode == M_INVUL) begin
            if (heal) m_hp = (m_hp + 1 > MAX_HP) ? MAX_HP : m_hp + 1;
            if (rise) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_mode = M_ALIVE;
            end
        end
    endfunction

    function automatic logic [11:0] exp_pix(input int hc, input int vc, input logic [11:0] rgb);
        int  il, ir, it, ib;
        logic in_int, in_out, fill_on;
        il = BAR_LEFT; ir = BAR_LEFT + MAX_HP * SEG_W;
        it = BAR_TOP;  ib = BAR_TOP + BAR_H;
        if (m_mode == M_OFF) return rgb;
        in_int = (hc >= il) && (hc < ir) && (vc >= it) && (vc < ib);
        in_out = (hc >= il - BORDER) && (hc < ir + BORDER) && (vc >= it - BORDER) && (vc < ib + BORDER);
`ifdef HP_BAR_BLINK_EN
        fill_on = !((m_mode == M_INVUL) && (((m_cnt >> 2) & 1) == 1));
`else
        fill_on = 1'b1;
`endif
        if (in_out && !in_int) return 12'hfff;
        if (in_int && fill_on && (hc < il + m_hp * SEG_W)) return (m_hp <= LOW_HP) ? 12'hf00 : 12'h0f0;
        return rgb;
    endfunction

    task automatic tick();
        e_rgb  = exp_pix(int'(hcount_in), int'(vcount_in), rgb_in);
        e_hc   = hcount_in;
        e_vc   = vcount_in;
        e_sync = {vsync_in, vblnk_in, hsync_in, hblnk_in};
        @(posedge pclk);
        model_step();
        #1;
    endtask

    task automatic wait_frames(input int n);
        hit = 1'b0; heal = 1'b0;
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1; tick();
            vsync_in = 1'b0; tick();
        end
    endtask

    task automatic restart_game();
        hit = 1'b0; heal = 1'b0;
        game_on = 1'b0; tick();
        game_on = 1'b1; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; game_on = 1'b0; hit = 1'b0; heal = 1'b0; dmg_amount = 3'd0;
        hcount_in = 12'd100; vcount_in = 12'd200; rgb_in = 12'h5a5;
        vsync_in = 1'b0; vblnk_in = 1'b1; hsync_in = 1'b1; hblnk_in = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        n_tests++;
        if (rgb_out !== 12'h0 || hcount_out !== 12'h0 || vcount_out !== 12'h0 ||
            {vsync_out, vblnk_out, hsync_out, hblnk_out} !== 4'b0) begin
            n_fail++; $display("FAIL reset_outputs: rgb=%h hc=%0d vc=%0d sync=%b, want all 0",
                               rgb_out, hcount_out, vcount_out, {vsync_out, vblnk_out, hsync_out, hblnk_out});
        end
        n_tests++;
        if (hp_level !== 3'd5 || invul !== 1'b0 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: hp=%0d invul=%b go=%b, want 5 0 0", hp_level, invul, game_over);
        end
        rst_n = 1'b1; model_reset();
        game_on = 1'b1; tick();
        hit = 1'b1; dmg_amount = 3'd3; tick(); hit = 1'b0;
        n_tests++;
        if (hp_level !== 3'd2 || invul !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_hp: hp=%0d invul=%b, want 2 1", hp_level, invul);
        end
        hcount_in = 12'd500; vcount_in = 12'd740; vsync_in = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (rgb_out !== 12'h0 || hcount_out !== 12'h0 || vcount_out !== 12'h0 ||
            {vsync_out, vblnk_out, hsync_out, hblnk_out} !== 4'b0 || invul !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset: rgb=%h hc=%0d vc=%0d invul=%b, want 0", rgb_out, hcount_out, vcount_out, invul);
        end
        game_on = 1'b0; vsync_in = 1'b0;
        @(posedge pclk); #1;
        rst_n = 1'b1; model_reset();
        tick();
        n_tests++;
        if (hp_level !== 3'd5 || invul !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_hp: hp=%0d invul=%b, want 5 0", hp_level, invul);
        end
        hcount_in = 12'd123; vcount_in = 12'd456; rgb_in = 12'h9c3;
        {vsync_in, vblnk_in, hsync_in, hblnk_in} = 4'b1010;
        tick();
        n_tests++;
        if (hcount_out !== 12'd123 || vcount_out !== 12'd456 || rgb_out !== 12'h9c3 ||
            {vsync_out, vblnk_out, hsync_out, hblnk_out} !== 4'b1010) begin
            n_fail++; $display("FAIL timing_lag: hc=%0d vc=%0d rgb=%h sync=%b, want 123 456 9c3 1010",
                               hcount_out, vcount_out, rgb_out, {vsync_out, vblnk_out, hsync_out, hblnk_out});
        end
        vsync_in = 1'b0;
    endtask

    task automatic test_hit_invul();
        restart_game();
        n_tests++;
        if (hp_level !== 3'd5 || invul !== 1'b0) begin
            n_fail++; $display("FAIL start_hp: hp=%0d invul=%b, want 5 0", hp_level, invul);
        end
        hit = 1'b1; dmg_amount = 3'd2; tick(); hit = 1'b0;
        n_tests++;
        if (hp_level !== 3'd3 || invul !== 1'b1 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL hit_dmg2: hp=%0d invul=%b go=%b, want 3 1 0", hp_level, invul, game_over);
        end
        hit = 1'b1; dmg_amount = 3'd2; tick(); hit = 1'b0;
        n_tests++;
        if (hp_level !== 3'd3 || invul !== 1'b1) begin
            n_fail++; $display("FAIL hit_in_invul: hp=%0d invul=%b, want 3 1", hp_level, invul);
        end
        wait_frames(INVUL_FRAMES - 1);
        n_tests++;
        if (invul !== 1'b1) begin
            n_fail++; $display("FAIL invul_59: invul=%b, want 1", invul);
        end
        wait_frames(1);
        n_tests++;
        if (invul !== 1'b0 || hp_level !== 3'd3) begin
            n_fail++; $display("FAIL invul_end: invul=%b hp=%0d, want 0 3", invul, hp_level);
        end
    endtask

    task automatic test_heal();
        restart_game();
        heal = 1'b1; tick(); heal = 1'b0;
        n_tests++;
        if (hp_level !== 3'd5) begin
            n_fail++; $display("FAIL heal_at_max: hp=%0d, want 5", hp_level);
        end
        hit = 1'b1; dmg_amount = 3'd2; tick(); hit = 1'b0;
        wait_frames(INVUL_FRAMES);
        hit = 1'b1; heal = 1'b1; dmg_amount = 3'd1; tick(); hit = 1'b0; heal = 1'b0;
        n_tests++;
        if (hp_level !== 3'd2 || invul !== 1'b1) begin
            n_fail++; $display("FAIL hit_heal_same: hp=%0d invul=%b, want 2 1", hp_level, invul);
        end
        heal = 1'b1; tick(); heal = 1'b0;
        n_tests++;
        if (hp_level !== 3'd3 || invul !== 1'b1) begin
            n_fail++; $display("FAIL heal_in_invul: hp=%0d invul=%b, want 3 1", hp_level, invul);
        end
    endtask

    task automatic test_draw();
        wait_frames(INVUL_FRAMES);
        vcount_in = 12'(BAR_TOP); rgb_in = 12'h123;
        hcount_in = 12'(BAR_LEFT + 179); tick();
        n_tests++;
        if (rgb_out !== 12'h0f0) begin
            n_fail++; $display("FAIL fill_last_px: rgb=%h, want 0f0", rgb_out);
        end
        hcount_in = 12'(BAR_LEFT + 180); tick();
        n_tests++;
        if (rgb_out !== 12'h123) begin
            n_fail++; $display("FAIL past_fill: rgb=%h, want 123", rgb_out);
        end
        hcount_in = 12'(BAR_LEFT - 1); tick();
        n_tests++;
        if (rgb_out !== 12'hfff) begin
            n_fail++; $display("FAIL frame_left: rgb=%h, want fff", rgb_out);
        end
        hcount_in = 12'(BAR_LEFT - BORDER - 1); tick();
        n_tests++;
        if (rgb_out !== 12'h123) begin
            n_fail++; $display("FAIL outside_frame: rgb=%h, want 123", rgb_out);
        end
        hit = 1'b1; dmg_amount = 3'd2; tick(); hit = 1'b0;
        wait_frames(INVUL_FRAMES);
        hcount_in = 12'(BAR_LEFT); vcount_in = 12'(BAR_TOP + BAR_H - 1); tick();
        n_tests++;
        if (rgb_out !== 12'hf00 || hp_level !== 3'd1) begin
            n_fail++; $display("FAIL low_red: rgb=%h hp=%0d, want f00 1", rgb_out, hp_level);
        end
    endtask

    task automatic test_death();
        hit = 1'b1; dmg_amount = 3'd7; tick(); hit = 1'b0;
        n_tests++;
        if (hp_level !== 3'd0 || game_over !== 1'b1 || invul !== 1'b0) begin
            n_fail++; $display("FAIL death: hp=%0d go=%b invul=%b, want 0 1 0", hp_level, game_over, invul);
        end
        hcount_in = 12'(BAR_LEFT); vcount_in = 12'(BAR_TOP); rgb_in = 12'h2b4;
        hit = 1'b1; dmg_amount = 3'd1; tick(); hit = 1'b0;
        n_tests++;
        if (game_over !== 1'b0 || hp_level !== 3'd0 || invul !== 1'b0) begin
            n_fail++; $display("FAIL dead_hold: go=%b hp=%0d invul=%b, want 0 0 0", game_over, hp_level, invul);
        end
        n_tests++;
        if (rgb_out !== 12'h2b4) begin
            n_fail++; $display("FAIL dead_no_fill: rgb=%h, want 2b4", rgb_out);
        end
        hcount_in = 12'(BAR_LEFT + MAX_HP * SEG_W); tick();
        n_tests++;
        if (rgb_out !== 12'hfff) begin
            n_fail++; $display("FAIL dead_frame: rgb=%h, want fff", rgb_out);
        end
    endtask

    task automatic test_off_in_invul();
        logic [11:0] want;
        restart_game();
        hit = 1'b1; dmg_amount = 3'd3; tick(); hit = 1'b0;
        n_tests++;
        if (hp_level !== 3'd2 || invul !== 1'b1) begin
            n_fail++; $display("FAIL invul_hp2: hp=%0d invul=%b, want 2 1", hp_level, invul);
        end
        hcount_in = 12'(BAR_LEFT); vcount_in = 12'(BAR_TOP); rgb_in = 12'h456;
        tick();
`ifdef HP_BAR_BLINK_EN
        want = 12'h456;
`else
        want = 12'h0f0;
`endif
        n_tests++;
        if (rgb_out !== want) begin
            n_fail++; $display("FAIL invul_fill_cnt60: rgb=%h, want %h", rgb_out, want);
        end
        wait_frames(1);
        tick();
        n_tests++;
        if (rgb_out !== 12'h0f0) begin
            n_fail++; $display("FAIL invul_fill_cnt59: rgb=%h, want 0f0", rgb_out);
        end
        game_on = 1'b0; tick();
        n_tests++;
        if (hp_level !== 3'd5 || invul !== 1'b0 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL off_from_invul: hp=%0d invul=%b go=%b, want 5 0 0", hp_level, invul, game_over);
        end
        hcount_in = 12'(BAR_LEFT - 1); tick();
        n_tests++;
        if (rgb_out !== 12'h456) begin
            n_fail++; $display("FAIL off_passthru: rgb=%h, want 456", rgb_out);
        end
    endtask

    task automatic test_random();
        int errs_state = 0, errs_pix = 0;
        for (int i = 0; i < 2500; i++) begin
            if (game_on) game_on = ($urandom_range(0, 149) != 0);
            else         game_on = ($urandom_range(0, 2) == 0);
            hit        = ($urandom_range(0, 7) == 0);
            heal       = ($urandom_range(0, 7) == 0);
            dmg_amount = 3'($urandom_range(0, 7));
            vsync_in   = 1'($urandom_range(0, 1));
            vblnk_in   = 1'($urandom_range(0, 1));
            hsync_in   = 1'($urandom_range(0, 1));
            hblnk_in   = 1'($urandom_range(0, 1));
            rgb_in     = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) begin
                hcount_in = 12'($urandom_range(0, 4095));
                vcount_in = 12'($urandom_range(0, 4095));
            end else begin
                hcount_in = 12'($urandom_range(BAR_LEFT - 15, BAR_LEFT + MAX_HP * SEG_W + 15));
                vcount_in = 12'($urandom_range(BAR_TOP - 15, BAR_TOP + BAR_H + 15));
            end
            tick();
            n_tests++;
            if (hp_level !== 3'(m_hp) || invul !== (m_mode == M_INVUL) || game_over !== m_go) begin
                n_fail++;
                if (errs_state < 5) $display("FAIL rand_state[%0d]: hp=%0d invul=%b go=%b, want %0d %b %b",
                                             i, hp_level, invul, game_over, m_hp, (m_mode == M_INVUL), m_go);
                errs_state++;
            end
            n_tests++;
            if (rgb_out !== e_rgb || hcount_out !== e_hc || vcount_out !== e_vc ||
                {vsync_out, vblnk_out, hsync_out, hblnk_out} !== e_sync) begin
                n_fail++;
                if (errs_pix < 5) $display("FAIL rand_pixel[%0d]: rgb=%h hc=%0d vc=%0d, want %h %0d %0d",
                                           i, rgb_out, hcount_out, vcount_out, e_rgb, e_hc, e_vc);
                errs_pix++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_hit_invul();
        test_heal();
        test_draw();
        test_death();
        test_off_in_invul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
